// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong absorb front end.
// The ERR state exists only when EAGLESONG_ABSORB_WATCHDOG_EN is defined.
package eaglesong_pkg;

  localparam int         RATE_WORDS    = 8;
  localparam int         STATE_WORDS   = 16;
  localparam logic [7:0] DELIM_DEFAULT = 8'h06;

  typedef logic [STATE_WORDS-1:0][31:0] state_t;
  typedef logic [RATE_WORDS-1:0][31:0]  blk_t;

  typedef enum logic [3:0] {
    IDLE,
    FILL,
    PAD,
    XOR,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    DONE
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
    ,
    ERR
`endif
  } fsm_state_e;

  // Digest byte 4j+k is byte k (LSB first) of rate word j; byte 0 lands in the top byte.
  function automatic logic [255:0] digest_of(input blk_t rate);
    logic [255:0] d;
    d = '0;
    for (int j = 0; j < RATE_WORDS; j++) begin
      for (int k = 0; k < 4; k++) begin
        d[255 - 8 * (4 * j + k) -: 8] = rate[j][8 * k +: 8];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/eaglesong_byte_packer.sv
// eaglesong_byte_packer: shifts message bytes and the pad delimiter into the
// 256-bit rate block; a partial word stays right-aligned.
module eaglesong_byte_packer
  import eaglesong_pkg::*;
#(
  parameter logic [7:0] DELIM = DELIM_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_en,
  input  logic [7:0] byte_in,
  input  logic       delim_en,
  input  logic       clear,
  output blk_t       blk,
  output logic [4:0] pos,
  output logic       full
);

  logic [7:0] wr_data;
  logic [2:0] wr_word;

  assign wr_data = delim_en ? DELIM : byte_in;
  assign wr_word = pos[4:2];

  // NOTE: blk is eight ordinary flop words consumed by the state XOR, not a RAM,
  // so it takes the async reset like every other register here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk  <= '0;
      pos  <= '0;
      full <= 1'b0;
    end else if (clear) begin
      blk  <= '0;
      pos  <= '0;
      full <= 1'b0;
    end else if (byte_en || delim_en) begin
      // NOTE: non-blocking assignments, so pos and blk read here are the pre-edge values.
      blk[wr_word] <= {blk[wr_word][23:0], 8'h00} ^ {24'h000000, wr_data};
      pos          <= pos + 5'd1;
      if (pos == 5'd31) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/eaglesong_absorb.sv
// eaglesong_absorb: byte-stream absorb stage feeding eaglesong_all_permutations.
// Define EAGLESONG_ABSORB_WATCHDOG_EN to bound the permutation wait (ERR state).
module eaglesong_absorb
  import eaglesong_pkg::*;
#(
  parameter logic [7:0] DELIM = DELIM_DEFAULT
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  input  logic         in_empty,
  output state_t       state_input,
  output logic         start_eval,
  input  state_t       state_output,
  input  logic         eval_output_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy,
  output logic         timeout_err
);

  fsm_state_e state, next_state;
  state_t     state_reg;
  logic       final_blk;
  logic       pad_pending;

  blk_t       blk;
  logic [4:0] pos;
  logic       blk_full;
  logic       byte_en;
  logic       delim_en;
  logic       blk_clear;

  assign byte_en   = (state == FILL) && in_valid && !(in_last && in_empty);
  assign delim_en  = (state == PAD) && !blk_full;
  assign blk_clear = (state == XOR);

  eaglesong_byte_packer #(
    .DELIM(DELIM)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .byte_en (byte_en),
    .byte_in (in_byte),
    .delim_en(delim_en),
    .clear   (blk_clear),
    .blk     (blk),
    .pos     (pos),
    .full    (blk_full)
  );

  // The permutation reads the sponge state directly; it only changes on capture.
  assign state_input = state_reg;
  assign digest      = digest_of(state_reg[RATE_WORDS-1:0]);

`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == WAIT_LO || state == WAIT_HI) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: next_state defaults to the current state so no branch can infer a latch.
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = FILL;
      FILL: begin
        if (in_valid) begin
          if (in_last) begin
            next_state = PAD;
          end else if (pos == 5'd31) begin
            next_state = XOR;
          end
        end
      end
      PAD:     next_state = XOR;
      XOR:     next_state = ISSUE;
      ISSUE:   next_state = WAIT_LO;
      WAIT_LO: begin
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
        if (wd_expired) next_state = ERR;
        else
`endif
        if (!eval_output_ready) next_state = WAIT_HI;
      end
      WAIT_HI: begin
        // A result arriving on the expiry edge is still taken.
        if (eval_output_ready) begin
          if (pad_pending)    next_state = PAD;
          else if (final_blk) next_state = DONE;
          else                next_state = FILL;
        end
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
        else if (wd_expired) next_state = ERR;
`endif
      end
      DONE:    if (digest_ready) next_state = IDLE;
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
      ERR:     next_state = ERR;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    start_eval   = 1'b0;
    digest_valid = 1'b0;
    busy         = (state != IDLE);
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
    timeout_err  = (state == ERR);
`else
    timeout_err  = 1'b0;
`endif
    case (state)
      FILL:    in_ready     = 1'b1;
      ISSUE:   start_eval   = 1'b1;
      DONE:    digest_valid = 1'b1;
      default: ;
    endcase
  end

  // Sponge state and the end-of-message flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= '0;
      final_blk   <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        PAD: begin
          // A block that ended exactly full needs one more block holding only the delimiter.
          if (blk_full) pad_pending <= 1'b1;
          else          final_blk   <= 1'b1;
        end
        XOR: state_reg[RATE_WORDS-1:0] <= state_reg[RATE_WORDS-1:0] ^ blk;
        WAIT_HI: begin
          if (eval_output_ready) begin
            state_reg   <= state_output;
            pad_pending <= 1'b0;
          end
        end
        DONE: begin
          if (digest_ready) begin
            state_reg   <= '0;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eaglesong_absorb.sv
// Self-checking bench for eaglesong_absorb with a mock permutation and a
// message-level sponge reference model.
module tb_eaglesong_absorb;
  import eaglesong_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         in_empty;
  state_t       state_input;
  logic         start_eval;
  state_t       state_output;
  logic         eval_output_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;
  logic         timeout_err;

  eaglesong_absorb dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_byte          (in_byte),
    .in_last          (in_last),
    .in_empty         (in_empty),
    .state_input      (state_input),
    .start_eval       (start_eval),
    .state_output     (state_output),
    .eval_output_ready(eval_output_ready),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .digest_ready     (digest_ready),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int           checks;
  int           errors;
  logic [7:0]   msg_q[$];
  state_t       exp_issue_q[$];
  logic [255:0] exp_digest;
  state_t       issue_q[$];
  state_t       out_q[$];
  int           start_long;
  bit           start_prev;
  bit           perm_hang;

  // Stand-in permutation: any fixed mixing of the full state will do.
  function automatic state_t perm_mock(input state_t s);
    state_t o;
    for (int i = 0; i < 16; i++) begin
      o[i] = {s[i][18:0], s[i][31:19]} ^ s[(i + 5) % 16] ^ (32'h9E3779B9 * 32'(i + 1));
    end
    return o;
  endfunction

  // Mock permutation: drops ready after a start, returns the result ~45 cycles later.
  initial begin
    state_t cap;
    int     cnt;
    bit     pend;
    cap = '0; cnt = 0; pend = 1'b0;
    eval_output_ready = 1'b1;
    state_output      = '0;
    forever begin
      @(negedge clk);
      if (start_eval && start_prev) start_long++;
      start_prev = start_eval;
      if (!reset_n) begin
        pend = 1'b0;
        eval_output_ready = 1'b1;
      end else if (start_eval) begin
        cap = state_input;
        issue_q.push_back(cap);
        eval_output_ready = 1'b0;
        cnt  = $urandom_range(44, 48);
        pend = 1'b1;
      end else if (pend && !perm_hang) begin
        cnt--;
        if (cnt == 0) begin
          state_output = perm_mock(cap);
          out_q.push_back(state_output);
          eval_output_ready = 1'b1;
          pend = 1'b0;
        end
      end
    end
  end

  // Reference: append the delimiter, cut into 32-byte blocks, each word is the
  // big-endian value of the bytes present in it, absorb into words 0..7, permute.
  task automatic model_msg();
    logic [7:0]  p[$];
    state_t      s;
    logic [31:0] word;
    int          nblk;
    int          idx;
    p = msg_q;
    p.push_back(8'h06);
    nblk = (p.size() + 31) / 32;
    s = '0;
    exp_issue_q.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 8; w++) begin
        word = '0;
        for (int k = 0; k < 4; k++) begin
          idx = b * 32 + w * 4 + k;
          if (idx < p.size()) word = (word << 8) | {24'h0, p[idx]};
        end
        s[w] = s[w] ^ word;
      end
      exp_issue_q.push_back(s);
      s = perm_mock(s);
    end
    for (int n = 0; n < 32; n++) exp_digest[255 - 8 * n -: 8] = s[n / 4][8 * (n % 4) +: 8];
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    in_byte = 8'h00; digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_beat(input logic [7:0] b, input logic last, input logic empty,
                            input bit throttle, inout bit ok);
    int budget;
    bit acc;
    if (throttle) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_last = last; in_empty = empty;
    budget = 0; acc = 1'b0;
    while (!acc && budget < 500) begin
      acc = in_ready;
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    if (!acc) ok = 1'b0;
  endtask

  task automatic send_msg(input bit throttle, input bit sep_last);
    int n;
    bit ok;
    n = msg_q.size();
    ok = 1'b1;
    issue_q.delete();
    out_q.delete();
    for (int i = 0; i < n; i++) drive_beat(msg_q[i], (i == n - 1) && !sep_last, 1'b0, throttle, ok);
    if (n == 0 || sep_last) drive_beat(8'($urandom), 1'b1, 1'b1, throttle, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL msg_accept: in_ready stalled got %0b want 1", ok);
    end
  endtask

  task automatic finish_msg(input int ready_delay, input bit early,
                            output logic [255:0] dig, output bit stable, output bit got);
    int budget;
    budget = 0; stable = 1'b1; dig = '0;
    if (early) digest_ready = 1'b1;
    while (!digest_valid && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    got = digest_valid;
    dig = digest;
    if (got) begin
      for (int i = 0; i < ready_delay; i++) begin
        @(negedge clk);
        if (!digest_valid || digest !== dig) stable = 1'b0;
      end
      digest_ready = 1'b1;
      @(negedge clk);
    end
    digest_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, start_eval, digest_valid, busy, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {in_ready, start_eval, digest_valid, busy, timeout_err});
    end
    apply_reset();
    checks++;
    if (digest !== '0) begin errors++; $display("FAIL reset_digest: got %h want 0", digest); end
    checks++;
    if (state_input !== '0) begin errors++; $display("FAIL reset_state_input: got %h want 0", state_input); end
    checks++;
    if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b want 00", {in_ready, busy}); end
  endtask

  task automatic test_hello();
    string        s;
    logic [255:0] dig;
    bit           stable, got;
    state_t       st;
    s = "Hello, world!\n";
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    model_msg();
    send_msg(1'b0, 1'b0);
    finish_msg(0, 1'b0, dig, stable, got);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL hello_done: digest_valid got %0b want 1", got); end
    checks++;
    if (issue_q.size() !== 1) begin errors++; $display("FAIL hello_perms: got %0d want 1", issue_q.size()); end
    if (issue_q.size() >= 1) begin
      st = issue_q[0];
      checks++;
      if (st[3:0] !== {32'h00210A06, 32'h6F726C64, 32'h6F2C2077, 32'h48656C6C} || st[15:4] !== '0) begin
        errors++;
        $display("FAIL hello_state_input: got %h want 00210a06_6f726c64_6f2c2077_48656c6c low words, rest 0", st);
      end
    end
    checks++;
    if (dig !== exp_digest) begin errors++; $display("FAIL hello_digest: got %h want %h", dig, exp_digest); end
    checks++;
    if ({busy, digest_valid} !== 2'b00 || digest !== '0 || state_input !== '0) begin
      errors++;
      $display("FAIL hello_return_idle: busy/valid got %b digest %h", {busy, digest_valid}, digest);
    end
  endtask

  task automatic test_zero_length();
    logic [255:0] dig;
    bit           stable, got;
    state_t       z;
    msg_q.delete();
    model_msg();
    send_msg(1'b0, 1'b0);
    finish_msg(0, 1'b0, dig, stable, got);
    z = '0;
    z[0] = 32'h00000006;
    checks++;
    if (issue_q.size() !== 1) begin errors++; $display("FAIL zero_perms: got %0d want 1", issue_q.size()); end
    if (issue_q.size() >= 1) begin
      checks++;
      if (issue_q[0] !== z) begin errors++; $display("FAIL zero_state_input: got %h want %h", issue_q[0], z); end
    end
    checks++;
    if (dig !== exp_digest) begin errors++; $display("FAIL zero_digest: got %h want %h", dig, exp_digest); end
  endtask

  // Messages of 32 and 33 bytes: look at what the second block XORed in.
  task automatic test_block_edge(input int len, input logic [255:0] want_blk2);
    logic [255:0] dig;
    bit           stable, got;
    state_t       i1, o0;
    msg_q.delete();
    for (int i = 0; i < len - 1; i++) msg_q.push_back(8'($urandom));
    msg_q.push_back((len == 33) ? 8'hAB : 8'($urandom));
    model_msg();
    send_msg(1'b0, 1'b0);
    finish_msg(0, 1'b0, dig, stable, got);
    checks++;
    if (issue_q.size() !== 2) begin errors++; $display("FAIL len%0d_perms: got %0d want 2", len, issue_q.size()); end
    if (issue_q.size() >= 2 && out_q.size() >= 1) begin
      i1 = issue_q[1];
      o0 = out_q[0];
      checks++;
      if ((i1[7:0] ^ o0[7:0]) !== want_blk2) begin
        errors++;
        $display("FAIL len%0d_blk2: got %h want %h", len, i1[7:0] ^ o0[7:0], want_blk2);
      end
      checks++;
      if (i1[15:8] !== o0[15:8]) begin
        errors++;
        $display("FAIL len%0d_capacity: got %h want %h", len, i1[15:8], o0[15:8]);
      end
    end
    checks++;
    if (dig !== exp_digest) begin errors++; $display("FAIL len%0d_digest: got %h want %h", len, dig, exp_digest); end
  endtask

  task automatic test_throttled();
    logic [255:0] d1, d2;
    bit           stable, got;
    msg_q.delete();
    for (int i = 0; i < 45; i++) msg_q.push_back(8'($urandom));
    model_msg();
    send_msg(1'b0, 1'b0);
    finish_msg(0, 1'b0, d1, stable, got);
    send_msg(1'b1, 1'b1);
    finish_msg(5, 1'b0, d2, stable, got);
    checks++;
    if (d1 !== exp_digest) begin errors++; $display("FAIL plain_digest: got %h want %h", d1, exp_digest); end
    checks++;
    if (d2 !== exp_digest) begin errors++; $display("FAIL throttled_digest: got %h want %h", d2, exp_digest); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL digest_hold: stable got %0b want 1", stable); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] dig;
    bit           stable, got, same;
    for (int m = 0; m < 6; m++) begin
      msg_q.delete();
      repeat ($urandom_range(0, 75)) msg_q.push_back(8'($urandom));
      model_msg();
      send_msg(1'($urandom), 1'($urandom));
      finish_msg(0, 1'($urandom), dig, stable, got);
      same = (issue_q.size() == exp_issue_q.size());
      for (int i = 0; i < issue_q.size() && same; i++) same = (issue_q[i] === exp_issue_q[i]);
      checks++;
      if (same !== 1'b1) begin
        errors++;
        $display("FAIL b2b_blocks[%0d]: got %0d blocks want %0d (or content differs)", m, issue_q.size(), exp_issue_q.size());
      end
      checks++;
      if (dig !== exp_digest) begin errors++; $display("FAIL b2b_digest[%0d]: got %h want %h", m, dig, exp_digest); end
    end
    checks++;
    if (start_long !== 0) begin errors++; $display("FAIL start_pulse: long pulses got %0d want 0", start_long); end
  endtask

  task automatic test_reset_mid_perm();
    logic [255:0] dig;
    bit           stable, got;
    int           budget;
    msg_q.delete();
    repeat (10) msg_q.push_back(8'($urandom));
    send_msg(1'b0, 1'b0);
    budget = 0;
    while (!start_eval && budget < 200) begin @(negedge clk); budget++; end
    checks++;
    if (start_eval !== 1'b1) begin errors++; $display("FAIL mid_issue: start_eval got %0b want 1", start_eval); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({start_eval, busy, in_ready} !== 3'b000 || state_input !== '0) begin
      errors++;
      $display("FAIL mid_reset: start/busy/ready got %b state_input %h", {start_eval, busy, in_ready}, state_input);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    msg_q.delete();
    repeat (5) msg_q.push_back(8'($urandom));
    model_msg();
    send_msg(1'b0, 1'b0);
    finish_msg(0, 1'b0, dig, stable, got);
    checks++;
    if (dig !== exp_digest) begin errors++; $display("FAIL post_reset_digest: got %h want %h", dig, exp_digest); end
  endtask

  task automatic test_watchdog();
    int budget;
    perm_hang = 1'b1;
    msg_q.delete();
    msg_q.push_back(8'h5A);
    send_msg(1'b0, 1'b0);
    budget = 0;
    while (!start_eval && budget < 200) begin @(negedge clk); budget++; end
    repeat (64) @(negedge clk);
`ifdef EAGLESONG_ABSORB_WATCHDOG_EN
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_early: timeout_err got %0b want 0", timeout_err); end
    @(negedge clk);
    checks++;
    if ({timeout_err, in_ready, busy} !== 3'b101) begin
      errors++;
      $display("FAIL wd_fire: err/ready/busy got %b want 101", {timeout_err, in_ready, busy});
    end
`else
    repeat (40) @(negedge clk);
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL wait_unbounded: err/busy got %b want 01", {timeout_err, busy});
    end
`endif
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, start_eval, digest_valid, busy, timeout_err} !== 5'b0 || digest !== '0 || state_input !== '0) begin
      errors++;
      $display("FAIL wd_reset: flags got %b", {in_ready, start_eval, digest_valid, busy, timeout_err});
    end
    perm_hang = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    checks = 0; errors = 0; start_long = 0; start_prev = 1'b0; perm_hang = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    in_empty = 1'b0; digest_ready = 1'b0;
    test_reset();
    test_hello();
    test_zero_length();
    test_block_edge(32, 256'h6);
    test_block_edge(33, 256'h0000AB06);
    test_throttled();
    test_back_to_back();
    test_reset_mid_perm();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
